btn_debounce: RTL
=================

# btn_debounce

Debounced push-button reader for the iCEBreaker-class board I/O path: takes a raw, asynchronous, bouncing button pin, synchronises it, samples it on a slow prescaled tick, and reports a clean level plus one-cycle press/release events and a press counter. It is the input-side counterpart to the LED drive logic: user logic consumes its events instead of clocking flops directly from raw buttons.

## Interface

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz
- SAMPLE_FREQ, 1000, sample-tick rate in Hz; DIV = CLK_FREQ / SAMPLE_FREQ, must be ≥ 2
- STABLE_SAMPLES, 20, consecutive agreeing samples required to change state, ≥ 1
- LONG_SAMPLES, 1000, samples held in PRESSED before long_press fires, ≥ 1
- COUNT_WIDTH, 8, width of press_count

Ports:
- clock  input  1  system clock; all state on posedge
- reset_n  input  1  asynchronous, active-low reset
- in  input  1  raw button pin, active-high, asynchronous to clock
- level  output  1  debounced button state, 1 = pressed
- press  output  1  one-cycle pulse on debounced press
- release  output  1  one-cycle pulse on debounced release
- press_count  output  COUNT_WIDTH  number of debounced presses, modulo 2^COUNT_WIDTH
- long_press  output  1  one-cycle pulse when a press has been held for LONG_SAMPLES samples

## Operation

- Synchroniser: two flops on in, reset to 0; sync is the second flop.
- Prescaler: 32-bit counter 0..DIV-1; tick is asserted for one cycle when count == DIV-1, then count wraps to 0.
- FSM states: RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE. Reset state is RELEASED. State and stable counter change only on tick cycles.
  - RELEASED: tick with sync=1 → CONFIRM_PRESS, stable=1. If STABLE_SAMPLES=1, go directly to PRESSED.
  - CONFIRM_PRESS: tick with sync=1 → stable+1; on reaching STABLE_SAMPLES → PRESSED. Tick with sync=0 → RELEASED, stable=0.
  - PRESSED: tick with sync=0 → CONFIRM_RELEASE, stable=1 (or RELEASED if STABLE_SAMPLES=1).
  - CONFIRM_RELEASE: mirror of CONFIRM_PRESS; a sync=1 sample returns to PRESSED with no events.
- On entry to PRESSED from a confirm path: level←1, press pulse, press_count+1 (wraps to 0 after 2^COUNT_WIDTH−1). On entry to RELEASED from CONFIRM_RELEASE: level←0, release pulse.
- Aborted confirms produce no event, and level remains unchanged.
- press and release never assert in the same cycle.

## Timing

- Reset values: level=0, press=0, release=0, press_count=0, long_press=0, prescaler=0, stable=0, state RELEASED.
- All outputs are registered. Pulses last exactly one clock.
- Press latency from a clean in edge: 2 sync cycles + 0..DIV-1 cycles to the first tick + (STABLE_SAMPLES−1)·DIV, then 1 cycle to the registered pulse. Release latency is the same.
- Reset mid-operation: everything returns to its reset values immediately. Partial confirms are discarded.
- A button held through reset deassertion is reported as a fresh press after STABLE_SAMPLES samples.

## Configuration

- BTN_DEBOUNCE_LONG_PRESS_EN defined:
  - A hold counter clears on entry to PRESSED and increments on each tick while in PRESSED or CONFIRM_RELEASE.
  - When the counter reaches LONG_SAMPLES, long_press pulses once. It saturates, with at most one pulse per press.
  - The counter clears on return to RELEASED.
- Not defined: the hold counter is not built and long_press is tied to 0. The port list is unchanged.

## Structure

- Package btn_pkg holds:
  - the btn_state_t enum (RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE)
  - default CLK_FREQ
- Sub-module sample_tick contains the synchroniser and the prescaler. It outputs sync and tick and takes parameter DIV.
- The FSM, counters and outputs live in btn_debounce.

## Test plan

Bench parameters: CLK_FREQ=100, SAMPLE_FREQ=10 (DIV=10), STABLE_SAMPLES=3, LONG_SAMPLES=8, COUNT_WIDTH=8.

- Hold reset_n low with in=1, then release → all outputs 0 during reset; after release, one press pulse within 33 cycles, press_count=1, level=1.
- Clean press: in 0→1, held 100 cycles → exactly one press pulse 23–32 cycles after the edge; no release pulse.
- Bounce: toggle in every 7 cycles for 60 cycles, then hold 0 → no press or release, press_count stays 0, level stays 0.
- Press/release repeated: 256 presses, each phase held 50 cycles → 256 press and 256 release pulses; press_count wraps to 0.
- Long press, macro on: hold in=1 for 150 cycles → exactly one long_press pulse about 80 cycles after press. Macro off → long_press is 0 throughout.
- Reset mid-confirm: assert reset_n low after 2 high samples, release with in=0 → no press pulse, press_count=0, level=0.

Source files
------------

// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
//   Shared types and defaults for the push-button debouncer.
//   - btn_state_t      : debouncer FSM states
//   - DEFAULT_CLK_FREQ : default system clock frequency in Hz
//   - DEFAULT_SAMPLE_FREQ : default debounce sample rate in Hz
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam int unsigned DEFAULT_CLK_FREQ    = 12_000_000;
    localparam int unsigned DEFAULT_SAMPLE_FREQ = 1_000;

    typedef enum logic [1:0] {
        RELEASED,
        CONFIRM_PRESS,
        PRESSED,
        CONFIRM_RELEASE
    } btn_state_t;

endpackage

// File: rtl/sample_tick.sv
// ---------------------------------------------------------------------------
// sample_tick
//   Input conditioning for the debouncer: a two-flop synchroniser on the raw
//   button pin and a free-running prescaler that produces the slow sample tick.
//
//   Parameters
//     DIV     : prescaler period in clock cycles (must be >= 2)
//   Ports
//     clock   : system clock, all state on posedge
//     reset_n : asynchronous active-low reset
//     in      : raw button pin, asynchronous to clock
//     sync    : synchronised copy of in (second flop)
//     tick    : one-cycle strobe every DIV cycles, while the count is DIV-1
// ---------------------------------------------------------------------------
module sample_tick #(
    parameter int unsigned DIV = 12_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic sync,
    output logic tick
);

    logic        meta;
    logic [31:0] count;

    // NOTE: non-blocking assignments make meta and sync two distinct flops;
    // blocking ones would collapse the chain into a single stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= in;
            sync <= meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign tick = (count == 32'(DIV - 1));

endmodule

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Debounced push-button reader. The raw pin is synchronised and sampled on
//   a slow tick; a four-state FSM requires STABLE_SAMPLES agreeing samples
//   before the debounced level changes, and reports one-cycle press/release
//   events plus a wrapping press counter.
//
//   Optional feature (macro BTN_DEBOUNCE_LONG_PRESS_EN):
//     defined     : long_press pulses once when a press has been held for
//                   LONG_SAMPLES samples
//     not defined : no hold counter, long_press tied to 0
//
//   Parameters
//     CLK_FREQ       : system clock frequency in Hz
//     SAMPLE_FREQ    : sample tick rate in Hz, CLK_FREQ/SAMPLE_FREQ >= 2
//     STABLE_SAMPLES : agreeing samples needed to change state, >= 1
//     LONG_SAMPLES   : samples held before long_press fires, >= 1
//     COUNT_WIDTH    : width of press_count
//   Ports
//     clock          : system clock, all state on posedge
//     reset_n        : asynchronous active-low reset
//     in             : raw button pin, active-high
//     level          : debounced state, 1 = pressed
//     press          : one-cycle pulse on debounced press
//     release_pulse  : one-cycle pulse on debounced release
//                      (named so because `release` is a reserved word)
//     press_count    : debounced presses modulo 2^COUNT_WIDTH
//     long_press     : one-cycle pulse after LONG_SAMPLES samples held
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter int unsigned SAMPLE_FREQ    = DEFAULT_SAMPLE_FREQ,
    parameter int unsigned STABLE_SAMPLES = 20,
    parameter int unsigned LONG_SAMPLES   = 1000,
    parameter int unsigned COUNT_WIDTH    = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in,
    output logic                   level,
    output logic                   press,
    output logic                   release_pulse,
    output logic [COUNT_WIDTH-1:0] press_count,
    output logic                   long_press
);

    localparam int unsigned DIV      = CLK_FREQ / SAMPLE_FREQ;
    localparam int unsigned STABLE_W = $clog2(STABLE_SAMPLES + 1);

    logic                sync;
    logic                tick;
    btn_state_t          state;
    logic [STABLE_W-1:0] stable;
    logic                last_sample;

    sample_tick #(
        .DIV (DIV)
    ) u_sample_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (in),
        .sync    (sync),
        .tick    (tick)
    );

    // stable is 0 in RELEASED/PRESSED, so this single compare also covers
    // STABLE_SAMPLES == 1, where the first disagreeing sample commits at once.
    assign last_sample = (stable == STABLE_W'(STABLE_SAMPLES - 1));

    // NOTE: every flop here, prescaler included, has an async reset so that a
    // reset mid-confirm discards partial progress and the tick phase restarts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RELEASED;
            stable        <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            // Pulses default low so each event lasts exactly one clock.
            press         <= 1'b0;
            release_pulse <= 1'b0;

            if (tick) begin
                unique case (state)
                    RELEASED, CONFIRM_PRESS: begin
                        if (sync) begin
                            if (last_sample) begin
                                state       <= PRESSED;
                                stable      <= '0;
                                level       <= 1'b1;
                                press       <= 1'b1;
                                press_count <= press_count + 1'b1;
                            end else begin
                                state  <= CONFIRM_PRESS;
                                stable <= stable + 1'b1;
                            end
                        end else begin
                            // Aborted confirm: no event, level untouched.
                            state  <= RELEASED;
                            stable <= '0;
                        end
                    end

                    PRESSED, CONFIRM_RELEASE: begin
                        if (!sync) begin
                            if (last_sample) begin
                                state         <= RELEASED;
                                stable        <= '0;
                                level         <= 1'b0;
                                release_pulse <= 1'b1;
                            end else begin
                                state  <= CONFIRM_RELEASE;
                                stable <= stable + 1'b1;
                            end
                        end else begin
                            state  <= PRESSED;
                            stable <= '0;
                        end
                    end

                    default: begin
                        state  <= RELEASED;
                        stable <= '0;
                    end
                endcase
            end
        end
    end

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_SAMPLES + 1);

    logic [HOLD_W-1:0] hold;

    // The counter sits at zero until the FSM commits a press, so it starts
    // from zero on entry to PRESSED. An aborted release returns to PRESSED
    // without clearing it, which keeps the one-pulse-per-press guarantee.
    // Saturating at LONG_SAMPLES stops a second pulse on a long hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state == RELEASED || state == CONFIRM_PRESS) begin
                hold <= '0;
            end else if (tick && hold != HOLD_W'(LONG_SAMPLES)) begin
                hold <= hold + 1'b1;
                if (hold == HOLD_W'(LONG_SAMPLES - 1)) begin
                    long_press <= 1'b1;
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
